// File: rtl/circuit6_seq_ctrl.sv
// Sequenced circuit6: z = ((a % c) == zero) ? a-1 : c+1, signed, via a restoring remainder unit.
// Optional macro CIRCUIT6_SEQ_EARLY_TERM_EN skips the divide loop when |a| < |c|.
module circuit6_seq_ctrl #(
    parameter int DATAWIDTH = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [DATAWIDTH-1:0] a,
    input  logic signed [DATAWIDTH-1:0] b,
    input  logic signed [DATAWIDTH-1:0] c,
    input  logic signed [DATAWIDTH-1:0] zero,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [DATAWIDTH-1:0] z,
    output logic                        dz,
    output logic [1:0]                  dbg_state
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // in_ready is high only in IDLE, out_valid holds with z/dz stable until out_ready.
    localparam int CW = $clog2(DATAWIDTH);
    localparam logic signed [DATAWIDTH-1:0] ONE = DATAWIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_SEL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                      state_q;
    logic signed [DATAWIDTH-1:0] a_q, c_q, zero_q, z_q;
    logic        [DATAWIDTH-1:0] abs_a_q, abs_c_q, rem_q;
    logic        [CW-1:0]        cnt_q;
    logic                        dz_pend_q, dz_q, out_valid_q;

    logic        [DATAWIDTH-1:0] abs_a_in_d, abs_c_in_d, rem_shift_d, rem_next_d;
    logic signed [DATAWIDTH-1:0] g_d;
    logic                        unused_b;

    always_comb begin
        abs_a_in_d  = a[DATAWIDTH-1] ? $unsigned(-a) : $unsigned(a);
        abs_c_in_d  = c[DATAWIDTH-1] ? $unsigned(-c) : $unsigned(c);
        // The remainder never reaches 2^(DATAWIDTH-1), so its MSB is free to shift out.
        rem_shift_d = {rem_q[DATAWIDTH-2:0], abs_a_q[DATAWIDTH-1]};
        rem_next_d  = (rem_shift_d >= abs_c_q) ? (rem_shift_d - abs_c_q) : rem_shift_d;
        if (dz_pend_q) begin
            g_d = a_q;
        end else if (a_q[DATAWIDTH-1] && (rem_q != '0)) begin
            g_d = -$signed(rem_q);
        end else begin
            g_d = $signed(rem_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            c_q         <= '0;
            zero_q      <= '0;
            abs_a_q     <= '0;
            abs_c_q     <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            dz_pend_q   <= 1'b0;
            z_q         <= '0;
            dz_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q       <= a;
                        c_q       <= c;
                        zero_q    <= zero;
                        abs_a_q   <= abs_a_in_d;
                        abs_c_q   <= abs_c_in_d;
                        rem_q     <= '0;
                        cnt_q     <= CW'(DATAWIDTH - 1);
                        dz_pend_q <= (c == '0);
                        if (c == '0) begin
                            state_q <= S_SEL;
                        end
`ifdef CIRCUIT6_SEQ_EARLY_TERM_EN
                        else if (abs_a_in_d < abs_c_in_d) begin
                            rem_q   <= abs_a_in_d;
                            state_q <= S_SEL;
                        end
`endif
                        else begin
                            state_q <= S_DIV;
                        end
                    end
                end
                S_DIV: begin
                    rem_q   <= rem_next_d;
                    abs_a_q <= abs_a_q << 1;
                    if (cnt_q == '0) begin
                        state_q <= S_SEL;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_SEL: begin
                    z_q         <= (g_d == zero_q) ? (a_q - ONE) : (c_q + ONE);
                    dz_q        <= dz_pend_q;
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign z         = z_q;
    assign dz        = dz_q;
    assign dbg_state = state_q;
    assign unused_b  = ^b;

endmodule

// File: tb/tb_circuit6_seq_ctrl.sv
// Self-checking bench for circuit6_seq_ctrl at DATAWIDTH=8: directed cases plus random operands
// against a behavioural model using the native signed % operator.
module tb_circuit6_seq_ctrl;
    localparam int DW = 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [DW-1:0] a = '0, b = '0, c = '0, zero = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic signed [DW-1:0] z;
    logic                 dz;
    logic [1:0]           dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW:0] exp_q[$];

    circuit6_seq_ctrl #(.DATAWIDTH(DW)) dut (
        .clk(clk), .rst(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .zero(zero),
        .out_valid(out_valid), .out_ready(out_ready),
        .z(z), .dz(dz), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Remainder with C semantics (sign follows dividend); c==0 selects a itself.
    function automatic int g_model(input logic signed [DW-1:0] ta, input logic signed [DW-1:0] tc);
        int av, cv;
        av = ta;
        cv = tc;
        if (cv == 0) return av;
        return av % cv;
    endfunction

    function automatic logic [DW:0] model(input logic signed [DW-1:0] ta, input logic signed [DW-1:0] tc,
                                          input logic signed [DW-1:0] tzero);
        int av, cv, zv;
        logic [DW-1:0] zz;
        av = ta;
        cv = tc;
        zv = tzero;
        if (g_model(ta, tc) == zv) zz = DW'(av - 1);
        else zz = DW'(cv + 1);
        return {(cv == 0), zz};
    endfunction

    function automatic int exp_lat(input logic signed [DW-1:0] ta, input logic signed [DW-1:0] tc);
        int av, cv;
        av = ta;
        cv = tc;
        if (cv == 0) return 1;
`ifdef CIRCUIT6_SEQ_EARLY_TERM_EN
        if ((av < 0 ? -av : av) < (cv < 0 ? -cv : cv)) return 1;
`endif
        return DW + 1;
    endfunction

    // Scoreboard compare: every cycle the result is presented, it must match the queue head.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_empty: out_valid high with no expected result");
            end else begin
                check("sb_z", longint'(z), longint'($signed(exp_q[0][DW-1:0])));
                check("sb_dz", longint'(dz), longint'(exp_q[0][DW]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic do_op(input logic signed [DW-1:0] ta, input logic signed [DW-1:0] tc,
                         input logic signed [DW-1:0] tzero, input int stall,
                         input bit chk_lit, input logic signed [DW-1:0] lit_z, input bit lit_dz);
        int n;
        int lat;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_wait", longint'(in_ready), 1);
        in_valid = 1'b1;
        a = ta;
        c = tc;
        zero = tzero;
        b = DW'($urandom);
        exp_q.push_back(model(ta, tc, tzero));
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = DW'($urandom);
        c = DW'($urandom);
        zero = DW'($urandom);
        check("busy_ready", longint'(in_ready), 0);
        lat = 0;
        while (!out_valid && lat < 200) begin
            in_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        check("latency", lat, exp_lat(ta, tc));
        if (chk_lit) begin
            check("lit_z", longint'(z), longint'(lit_z));
            check("lit_dz", longint'(dz), longint'(lit_dz));
        end
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            a = DW'($urandom);
            c = DW'($urandom);
            @(posedge clk); #1;
            check("stall_valid", longint'(out_valid), 1);
            check("stall_ready", longint'(in_ready), 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("drop_valid", longint'(out_valid), 0);
        check("idle_ready", longint'(in_ready), 1);
    endtask

    initial begin
        logic signed [DW-1:0] ra, rc, rz;
        logic signed [DW-1:0] prev_z;
        int pick;

        #23;
        check("rst_in_ready", longint'(in_ready), 1);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_z", longint'(z), 0);
        check("rst_dz", longint'(dz), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        check("model_10_3", longint'($signed(model(8'sd10, 8'sd3, 8'sd1))), longint'($signed({1'b0, 8'sd9})));
        check("model_m128_m1", longint'(model(-8'sd128, -8'sd1, 8'sd0)), 127);

        do_op(8'sd10, 8'sd3, 8'sd1, 0, 1'b1, 8'sd9, 1'b0);
        do_op(-8'sd7, 8'sd3, -8'sd1, 0, 1'b1, -8'sd8, 1'b0);
        do_op(8'sd7, -8'sd3, 8'sd1, 0, 1'b1, 8'sd6, 1'b0);
        do_op(8'sd20, 8'sd0, 8'sd20, 0, 1'b1, 8'sd19, 1'b1);
        do_op(-8'sd128, -8'sd1, 8'sd0, 0, 1'b1, 8'sd127, 1'b0);
        do_op(-8'sd128, -8'sd128, 8'sd0, 0, 1'b1, 8'sd127, 1'b0);
        do_op(8'sd5, -8'sd128, 8'sd5, 0, 1'b1, 8'sd4, 1'b0);
        do_op(8'sd0, 8'sd9, 8'sd0, 0, 1'b1, -8'sd1, 1'b0);
        do_op(8'sd5, 8'sd127, 8'sd0, 5, 1'b1, -8'sd128, 1'b0);

        // Abort mid-divide: outputs clear asynchronously and nothing is delivered.
        prev_z = z;
        check("pre_reset_z_nonzero", longint'(prev_z != 0), 1);
        in_valid = 1'b1;
        a = 8'sd50;
        c = 8'sd7;
        zero = 8'sd0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("abort_z", longint'(z), 0);
        check("abort_dz", longint'(dz), 0);
        check("abort_out_valid", longint'(out_valid), 0);
        check("abort_in_ready", longint'(in_ready), 1);
        exp_q.delete();
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(8'sd9, 8'sd4, 8'sd1, 0, 1'b1, 8'sd8, 1'b0);

        for (int k = 0; k < 150; k++) begin
            ra = DW'($urandom);
            pick = $urandom_range(0, 9);
            case (pick)
                0: rc = 8'sd0;
                1: rc = -8'sd1;
                2: rc = -8'sd128;
                3: rc = DW'($urandom_range(1, 7));
                default: rc = DW'($urandom);
            endcase
            if ($urandom_range(0, 5) == 0) ra = -8'sd128;
            if ($urandom_range(0, 1) == 0) rz = DW'(g_model(ra, rc));
            else rz = DW'($urandom);
            do_op(ra, rc, rz, $urandom_range(0, 3), 1'b0, 8'sd0, 1'b0);
        end

        check("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/circuit6_seq_ctrl.md
Name: circuit6_seq_ctrl

Overview:
- Multi-cycle sequenced implementation of the circuit6 function: z = ((a % c) == zero) ? (a - 1) : (c + 1), all signed.
- Replaces the single-cycle combinational 64-bit signed modulo with an iterative restoring remainder unit, one quotient bit per cycle.
- Sits between an upstream operand source and a downstream consumer, with valid/ready handshakes on both sides.
- Includes an FSM, a bit counter and a registered result.

Parameters:
- DATAWIDTH, 64, operand/result width in bits; legal range 2..64.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand set on a/b/c/zero is valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  DATAWIDTH  signed dividend; decrement operand.
- b  input  DATAWIDTH  signed, unused; retained for interface compatibility.
- c  input  DATAWIDTH  signed divisor; increment operand.
- zero  input  DATAWIDTH  signed comparison value.
- out_valid  output  1  z/dz are valid.
- out_ready  input  1  consumer accepts the result.
- z  output  DATAWIDTH  signed result.
- dz  output  1  divide-by-zero flag for the current result.

Behaviour:
- Reset (rst low, async): state=IDLE, in_ready=1, out_valid=0, z=0, dz=0, counter=0, internal operand registers=0.
- Reset mid-operation aborts the operation with no output. The first in_valid accepted after rst rises starts a fresh operation.
- FSM states: IDLE, DIV, SEL, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: capture a, c, zero; capture |a| and |c| as unsigned DATAWIDTH values (two's-complement magnitude; MIN magnitude = 2^(DATAWIDTH-1)); clear partial remainder; counter=DATAWIDTH-1.
  - If c==0, go to SEL with dz pending. Otherwise go to DIV.
- DIV:
  - Each cycle, shift the next |a| bit (MSB first) into the remainder; subtract |c| when the remainder >= |c|.
  - Decrement the counter. When counter==0, go to SEL.
  - Exactly DATAWIDTH cycles in DIV.
- SEL, one cycle:
  - g = remainder with the sign of a (negate if a<0 and remainder!=0). If dz is pending, g = a.
  - z <= (g==zero) ? a-1 : c+1, modulo 2^DATAWIDTH: a=MIN gives MAX; c=MAX gives MIN.
  - dz <= (c==0).
  - Go to DONE.
- DONE:
  - out_valid=1; z and dz held stable.
  - When out_ready is high, clear out_valid and go to IDLE on the same edge.
  - z and dz retain their values after the handshake.
- Latency:
  - Accepting edge to out_valid high: DATAWIDTH+2 edges normally; 2 edges when c==0.
  - Minimum initiation interval: latency+1 cycles. in_ready is low in DIV, SEL and DONE.
- Arithmetic:
  - Sign of the remainder follows the dividend.
  - MIN % -1 = 0.
  - x % MIN = x for x != MIN; MIN % MIN = 0.
- in_valid outside IDLE is ignored; operands are sampled only on the accepting edge.
- Operand input changes after acceptance have no effect.
- out_ready low in DONE stalls the block indefinitely.

Optional Feature:
- Macro: CIRCUIT6_SEQ_EARLY_TERM_EN.
- Defined:
  - In IDLE on acceptance, if c!=0 and |a| < |c|, set remainder=|a|, skip DIV and go directly to SEL. Latency is 2 edges.
  - If |a|==0, the remainder is 0 and the block also skips to SEL.
- Undefined: DIV always runs DATAWIDTH cycles for c!=0.
- Results are identical with and without the macro; only latency differs.

Test Plan:
- DATAWIDTH=8, a=10, c=3, zero=1: g=1 matches zero -> z=9, dz=0, out_valid high 10 edges after acceptance.
- DATAWIDTH=8, a=-7, c=3, zero=-1: g=-1 matches -> z=-8. Then a=7, c=-3, zero=1: g=1 -> z=6.
- DATAWIDTH=8, a=20, c=0, zero=20: dz=1, g=a matches -> z=19, out_valid 2 edges after acceptance.
- DATAWIDTH=8, a=-128, c=-1, zero=0: g=0 -> z=127 (wrap). a=5, c=127, zero=0: g=5 -> z=-128 (wrap). With CIRCUIT6_SEQ_EARLY_TERM_EN, the second case completes in 2 edges.
- Backpressure and handshake:
  - Hold out_ready low for 5 cycles in DONE: z, dz and out_valid are stable, and in_valid pulses are ignored (in_ready=0).
  - Raise out_ready: out_valid drops next edge, in_ready=1.
- Reset mid-operation: drive rst low during cycle 4 of DIV. Outputs are immediately z=0, dz=0, out_valid=0, in_ready=1. A new a=9, c=4, zero=1 then yields z=8.
